send_c2_arbiter: RTL and testbench
==================================

Name: send_c2_arbiter

Overview:
- Transmit side of the C2 router port; complements the C2 receive/route block.
- Merges packets from two upstream sources onto the single C2 output link:
  - C1 (sibling, C1_C2 channel pair)
  - P (parent, P_C2 channel pair)
- Each source uses a two-phase transfer: a 1-bit request token, then one 16-bit packet (header in [15:8], payload in [7:0]).
- Round-robin arbitration, one-packet output register, per-source packet counters.

Parameters:
- WIDTH, 16, packet width in bits (header = upper 8 bits).
- CNT_WIDTH, 8, width of each per-source packet counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- c1_req_valid  input  1  C1 request token valid
- c1_req_ready  output  1  C1 request token accepted
- c1_data  input  WIDTH  C1 packet
- c1_data_valid  input  1  C1 packet valid
- c1_data_ready  output  1  C1 packet accepted
- p_req_valid  input  1  P request token valid
- p_req_ready  output  1  P request token accepted
- p_data  input  WIDTH  P packet
- p_data_valid  input  1  P packet valid
- p_data_ready  output  1  P packet accepted
- c2_out_data  output  WIDTH  outgoing packet
- c2_out_valid  output  1  outgoing packet valid
- c2_out_ready  input  1  downstream accept
- c2_out_src  output  1  source of current packet (0 = C1, 1 = P)
- c1_pkt_cnt  output  CNT_WIDTH  packets forwarded from C1
- p_pkt_cnt  output  CNT_WIDTH  packets forwarded from P

Behaviour:
- Handshakes: a transfer occurs on a rising clk edge where valid && ready. Valid/data from producers are held until accepted.
- Reset (asynchronous, rst_n low):
  - state = IDLE, last_served = P.
  - c2_out_valid = 0, c2_out_data = 0, c2_out_src = 0.
  - Both counters = 0; all ready outputs = 0.
- States: IDLE, GET_C1, GET_P, SEND.
- IDLE:
  - grant is combinational. Only one req valid → that source. Both valid → the source that is not last_served.
  - req_ready of the granted source = 1; the other = 0. Both data_ready = 0.
  - On req handshake → GET_C1 or GET_P.
- GET_C1 / GET_P:
  - Only the granted source's data_ready = 1; both req_ready = 0.
  - On data handshake: latch data into c2_out_data, set c2_out_src, set c2_out_valid = 1, increment that source's counter, set last_served to the granted source, → SEND.
  - With no data_valid, wait indefinitely.
- SEND:
  - c2_out_valid, c2_out_data and c2_out_src stay stable until c2_out_ready.
  - On output handshake: c2_out_valid = 0 next cycle, → IDLE.
  - All input readies are 0 in SEND.
- Latency: req handshake at cycle N; data accepted earliest at N+1; c2_out_valid high from N+2. Peak throughput is one packet per 3 cycles.
- Boundary conditions:
  - data_valid asserted in IDLE or SEND, or by the non-granted source: ignored, not consumed.
  - req_valid of the non-granted source during GET/SEND: held pending; it wins the next IDLE tie by round-robin.
  - Counters wrap modulo 2^CNT_WIDTH (255 + 1 → 0).
  - Packet contents are passed through unmodified; no header inspection.
  - Reset mid-transfer (any state): packet discarded, outputs return to reset values immediately, no counter change is retained.

Test Plan:
- Single C1 packet: c1 req then c1_data=16'hA53C, c2_out_ready=1 → c2_out_data=16'hA53C, src=0, valid high exactly one cycle starting 2 cycles after req handshake; c1_pkt_cnt=1.
- Simultaneous requests after reset: both req_valid, packets C1=16'h1111, P=16'h2222 → output order 1111 (src 0) then 2222 (src 1). With both requesting continuously, sources alternate thereafter.
- Backpressure: c2_out_ready=0 for 5 cycles during SEND with P packet 16'h80FF → data/src/valid stable for all 5 cycles. All input readies stay 0. Packet sent once ready=1; p_pkt_cnt increments once.
- Delayed data: P req accepted, p_data_valid withheld 4 cycles, c1_data_valid held high meanwhile → stays GET_P, c1_data_ready=0. P packet forwarded first; C1 packet not consumed.
- Counter wrap: 256 C1 packets → c1_pkt_cnt returns to 0; p_pkt_cnt stays 0.
- Async reset in SEND with c2_out_valid=1 → valid drops without a clock edge. State IDLE, counters 0. Next request processed normally.

Source files
------------

// File: rtl/send_c2_arbiter.sv
// C2 transmit arbiter: merges C1 and P packet streams onto one output link
// with round-robin grant, a single-packet output register and per-source counters.
module send_c2_arbiter #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c1_req_valid,
    output logic                 c1_req_ready,
    input  logic [WIDTH-1:0]     c1_data,
    input  logic                 c1_data_valid,
    output logic                 c1_data_ready,
    input  logic                 p_req_valid,
    output logic                 p_req_ready,
    input  logic [WIDTH-1:0]     p_data,
    input  logic                 p_data_valid,
    output logic                 p_data_ready,
    output logic [WIDTH-1:0]     c2_out_data,
    output logic                 c2_out_valid,
    input  logic                 c2_out_ready,
    output logic                 c2_out_src,
    output logic [CNT_WIDTH-1:0] c1_pkt_cnt,
    output logic [CNT_WIDTH-1:0] p_pkt_cnt
);

    localparam logic SRC_C1 = 1'b0;
    localparam logic SRC_P  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_C1 = 2'd1,
        GET_P  = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic                 last_served_reg, last_served_next;
    logic [WIDTH-1:0]     out_data_reg, out_data_next;
    logic                 out_src_reg, out_src_next;
    logic                 out_valid_reg, out_valid_next;
    logic [CNT_WIDTH-1:0] cnt_reg [2];

    // Per-source views, index 0 = C1, index 1 = P
    logic [1:0]           req_valid;
    logic [1:0]           data_valid;
    logic [1:0]           req_ready_int;
    logic [1:0]           data_ready_int;
    logic                 grant_valid;
    logic                 grant_src;
    logic                 data_fire;
    logic                 fire_src;
    logic [WIDTH-1:0]     fire_data;

    assign req_valid  = {p_req_valid, c1_req_valid};
    assign data_valid = {p_data_valid, c1_data_valid};

    // Round-robin: on a tie, serve whichever source did not go last
    always_comb begin
        grant_valid = |req_valid;
        grant_src   = SRC_C1;
        case (req_valid)
            2'b01:   grant_src = SRC_C1;
            2'b10:   grant_src = SRC_P;
            2'b11:   grant_src = ~last_served_reg;
            default: grant_src = SRC_C1;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        req_ready_int  = 2'b00;
        data_ready_int = 2'b00;
        data_fire      = 1'b0;
        fire_src       = SRC_C1;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    req_ready_int[grant_src] = 1'b1;
                    state_next = (grant_src == SRC_P) ? GET_P : GET_C1;
                end
            end
            GET_C1: begin
                data_ready_int[0] = 1'b1;
                if (data_valid[0]) begin
                    data_fire  = 1'b1;
                    fire_src   = SRC_C1;
                    state_next = SEND;
                end
            end
            GET_P: begin
                data_ready_int[1] = 1'b1;
                if (data_valid[1]) begin
                    data_fire  = 1'b1;
                    fire_src   = SRC_P;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (c2_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fire_data = (fire_src == SRC_P) ? p_data : c1_data;

    always_comb begin
        out_data_next    = out_data_reg;
        out_src_next     = out_src_reg;
        out_valid_next   = out_valid_reg;
        last_served_next = last_served_reg;
        if (data_fire) begin
            out_data_next    = fire_data;
            out_src_next     = fire_src;
            out_valid_next   = 1'b1;
            last_served_next = fire_src;
        end else if (state_reg == SEND && c2_out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            last_served_reg <= SRC_P;
            out_data_reg    <= '0;
            out_src_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
            out_data_reg    <= out_data_next;
            out_src_reg     <= out_src_next;
            out_valid_reg   <= out_valid_next;
        end
    end

    // Counters wrap naturally at 2^CNT_WIDTH
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (data_fire && fire_src == 1'(gi)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    // Readies are forced low while reset is held, even if requests are pending
    assign c1_req_ready  = req_ready_int[0]  & rst_n;
    assign p_req_ready   = req_ready_int[1]  & rst_n;
    assign c1_data_ready = data_ready_int[0] & rst_n;
    assign p_data_ready  = data_ready_int[1] & rst_n;

    assign c2_out_data  = out_data_reg;
    assign c2_out_src   = out_src_reg;
    assign c2_out_valid = out_valid_reg;
    assign c1_pkt_cnt   = cnt_reg[0];
    assign p_pkt_cnt    = cnt_reg[1];

endmodule

// File: tb/tb_send_c2_arbiter.sv
// Self-checking bench for send_c2_arbiter: vector table, scoreboard monitor
// and hand-written sequences for arbitration, backpressure, wrap and reset.
module tb_send_c2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c1_req_valid = 1'b0;
    logic        c1_req_ready;
    logic [15:0] c1_data = '0;
    logic        c1_data_valid = 1'b0;
    logic        c1_data_ready;
    logic        p_req_valid = 1'b0;
    logic        p_req_ready;
    logic [15:0] p_data = '0;
    logic        p_data_valid = 1'b0;
    logic        p_data_ready;
    logic [15:0] c2_out_data;
    logic        c2_out_valid;
    logic        c2_out_ready = 1'b0;
    logic        c2_out_src;
    logic [7:0]  c1_pkt_cnt;
    logic [7:0]  p_pkt_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        src;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          src;
        logic [15:0] data;
        int          stall;
        logic [7:0]  exp_c1;
        logic [7:0]  exp_p;
    } vec_t;

    send_c2_arbiter #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
        .c1_data(c1_data), .c1_data_valid(c1_data_valid), .c1_data_ready(c1_data_ready),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
        .p_data(p_data), .p_data_valid(p_data_valid), .p_data_ready(p_data_ready),
        .c2_out_data(c2_out_data), .c2_out_valid(c2_out_valid), .c2_out_ready(c2_out_ready),
        .c2_out_src(c2_out_src), .c1_pkt_cnt(c1_pkt_cnt), .p_pkt_cnt(p_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        #2;
        if (rst_n && c2_out_valid && c2_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got %h src %0d expected none", c2_out_data, c2_out_src);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (c2_out_data !== e.data || c2_out_src !== e.src) begin
                    errors++;
                    $display("FAIL out_pkt: got %h src %0d expected %h src %0d",
                             c2_out_data, c2_out_src, e.data, e.src);
                end else begin
                    $display("pkt out data=%h src=%0d", c2_out_data, c2_out_src);
                end
            end
        end
    end

    task automatic set_req(input bit s, input logic v);
        if (s) p_req_valid = v; else c1_req_valid = v;
    endtask

    task automatic set_data(input bit s, input logic v, input logic [15:0] d);
        if (s) begin p_data_valid = v; p_data = d; end
        else   begin c1_data_valid = v; c1_data = d; end
    endtask

    function automatic logic get_rdy(input bit s, input bit is_data);
        if (is_data) return s ? p_data_ready : c1_data_ready;
        return s ? p_req_ready : c1_req_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic xfer(input bit s, input bit is_data, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        if (is_data) set_data(s, 1'b1, d); else set_req(s, 1'b1);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (get_rdy(s, is_data)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (is_data) set_data(s, 1'b0, d); else set_req(s, 1'b0);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout: src %0d data %0d got no ready expected ready", s, is_data);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    // One packet end to end, with optional downstream stall while in SEND
    task automatic run_pkt(input bit s, input logic [15:0] d, input int stall,
                           input logic [7:0] exp_c1, input logic [7:0] exp_p);
        c2_out_ready = (stall == 0);
        sb.push_back({s, d});
        xfer(s, 1'b0, d);
        chk("valid_after_req", c2_out_valid, 0);
        xfer(s, 1'b1, d);
        chk("valid_after_data", c2_out_valid, 1);
        chk("out_data", c2_out_data, d);
        chk("out_src", c2_out_src, s);
        for (int k = 0; k < stall; k++) begin
            c1_req_valid = 1'b1; p_req_valid = 1'b1;
            c1_data_valid = 1'b1; p_data_valid = 1'b1;
            #1;
            chk("stall_valid", c2_out_valid, 1);
            chk("stall_data", c2_out_data, d);
            chk("stall_src", c2_out_src, s);
            chk("stall_readies", {c1_req_ready, p_req_ready, c1_data_ready, p_data_ready}, 0);
            @(negedge clk);
        end
        c1_req_valid = 1'b0; p_req_valid = 1'b0;
        c1_data_valid = 1'b0; p_data_valid = 1'b0;
        c2_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid_after_send", c2_out_valid, 0);
        chk("c1_cnt", c1_pkt_cnt, exp_c1);
        chk("p_cnt", p_pkt_cnt, exp_p);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{src: 1'b0, data: 16'hA53C, stall: 0, exp_c1: 8'd1, exp_p: 8'd0};
        vecs[1] = '{src: 1'b1, data: 16'h80FF, stall: 5, exp_c1: 8'd1, exp_p: 8'd1};
        vecs[2] = '{src: 1'b0, data: 16'h0001, stall: 2, exp_c1: 8'd2, exp_p: 8'd1};
        vecs[3] = '{src: 1'b1, data: 16'hFFFF, stall: 0, exp_c1: 8'd2, exp_p: 8'd2};
        vecs[4] = '{src: 1'b1, data: 16'h0000, stall: 1, exp_c1: 8'd2, exp_p: 8'd3};

        // Reset state, with a request pending during reset
        c1_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_readies", {c1_req_ready, p_req_ready, c1_data_ready, p_data_ready}, 0);
        chk("rst_valid", c2_out_valid, 0);
        chk("rst_data", c2_out_data, 0);
        chk("rst_src", c2_out_src, 0);
        chk("rst_cnts", {c1_pkt_cnt, p_pkt_cnt}, 0);
        c1_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            $display("vector %0d src=%0d data=%h stall=%0d", i, vecs[i].src, vecs[i].data, vecs[i].stall);
            run_pkt(vecs[i].src, vecs[i].data, vecs[i].stall, vecs[i].exp_c1, vecs[i].exp_p);
        end

        // Delayed P data while C1 offers data without a grant
        c2_out_ready = 1'b1;
        xfer(1'b1, 1'b0, 16'h0);
        c1_data = 16'hBEEF;
        c1_data_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wait_p_data_ready", p_data_ready, 1);
            chk("wait_c1_data_ready", c1_data_ready, 0);
            chk("wait_valid", c2_out_valid, 0);
            @(negedge clk);
        end
        sb.push_back({1'b1, 16'h5555});
        xfer(1'b1, 1'b1, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        c1_data_valid = 1'b0;
        chk("delay_c1_cnt", c1_pkt_cnt, 8'd2);
        chk("delay_p_cnt", p_pkt_cnt, 8'd4);
        drain();
        $display("delayed data sequence done");

        // Simultaneous requests after reset: C1 first, then alternation
        do_reset();
        c2_out_ready = 1'b1;
        sb.push_back({1'b0, 16'h1111});
        sb.push_back({1'b1, 16'h2222});
        sb.push_back({1'b0, 16'h3333});
        sb.push_back({1'b1, 16'h4444});
        fork
            begin
                xfer(1'b0, 1'b0, 16'h0); xfer(1'b0, 1'b1, 16'h1111);
                xfer(1'b0, 1'b0, 16'h0); xfer(1'b0, 1'b1, 16'h3333);
            end
            begin
                xfer(1'b1, 1'b0, 16'h0); xfer(1'b1, 1'b1, 16'h2222);
                xfer(1'b1, 1'b0, 16'h0); xfer(1'b1, 1'b1, 16'h4444);
            end
        join
        drain();
        chk("rr_cnts", {c1_pkt_cnt, p_pkt_cnt}, {8'd2, 8'd2});
        $display("round-robin sequence done");

        // Counter wrap after 256 C1 packets
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_pkt(1'b0, 16'(i * 16'h0101), 0, 8'(i + 1), 8'd0);
        end
        chk("wrap_c1", c1_pkt_cnt, 0);
        chk("wrap_p", p_pkt_cnt, 0);
        $display("counter wrap sequence done");

        // Asynchronous reset while a packet sits in SEND
        c2_out_ready = 1'b0;
        sb.push_back({1'b0, 16'h6666});
        xfer(1'b0, 1'b0, 16'h0);
        xfer(1'b0, 1'b1, 16'h6666);
        chk("pre_rst_valid", c2_out_valid, 1);
        chk("pre_rst_cnt", c1_pkt_cnt, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", c2_out_valid, 0);
        chk("async_rst_data", c2_out_data, 0);
        chk("async_rst_cnt", c1_pkt_cnt, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pkt(1'b1, 16'h7777, 0, 8'd0, 8'd1);
        drain();
        $display("async reset sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
